sevenseg_scan_controller: RTL and testbench

Time-multiplexing scan controller for the 4-digit seven-segment display. Holds a 16-bit hex display word, decodes one digit at a time into a 13-bit frame (segments, decimal point, one-hot digit select), and offers each frame to the 13-bit seven-segment serializer over a valid/ready handshake. Each digit stays selected for a programmable dwell time before the scan advances. The block sits between the CPU output/debug registers and the serializer.

---
 rtl/sevenseg_scan_controller.sv | 174 +++++++++++++++++
 tb/tb_sevenseg_scan_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_controller.sv
// Four-digit seven-segment scan controller: decodes one hex digit at a time into a
// 13-bit frame, offers it over valid/ready, then dwells before advancing the scan.
module sevenseg_scan_controller #(
    parameter int unsigned DWELL_CYCLES = 1000
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic [15:0] i_DispData,
    input  logic [3:0]  i_DispDP,
    input  logic [3:0]  i_DispBlank,
    input  logic        i_Load,
    input  logic        i_FrameReady,
    output logic [12:0] o_Frame,
    output logic        o_FrameValid,
    output logic [1:0]  o_ScanIdx,
    output logic        o_ScanWrap
);

    localparam logic [15:0] DWELL_LOAD  = 16'(DWELL_CYCLES - 1);
    localparam logic [12:0] FRAME_RESET = 13'h0FFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_OFFER,
        S_DWELL
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [12:0] frame_q, frame_d;
    logic        wrap_q, wrap_d;

    logic [15:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic [3:0]  pend_blank_q, pend_blank_d;
    logic        pend_flag_q, pend_flag_d;

    logic [15:0] act_data_q, act_data_d;
    logic [3:0]  act_dp_q, act_dp_d;
    logic [3:0]  act_blank_q, act_blank_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Candidate frame for every digit position; FETCH just selects one of them.
    logic [12:0] digit_frame [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] SEL_N = ~(4'b0001 << gi);
            logic [6:0] seg;
            logic       dp_n;
            assign seg  = act_blank_q[gi] ? 7'h7F : hex_to_seg(act_data_q[gi*4 +: 4]);
            assign dp_n = act_blank_q[gi] ? 1'b1 : ~act_dp_q[gi];
            assign digit_frame[gi] = {1'b0, SEL_N, dp_n, seg};
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        wrap_d       = 1'b0;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_flag_d  = pend_flag_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;

        case (state_q)
            S_IDLE: begin
                idx_d   = 2'd0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                frame_d = digit_frame[idx_q];
                state_d = S_OFFER;
            end
            S_OFFER: begin
                if (i_FrameReady) begin
                    cnt_d   = DWELL_LOAD;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt_q == 16'd0) begin
                    idx_d   = idx_q + 2'd1;
                    wrap_d  = (idx_q == 2'd3);
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Commit sees the pending set as it was before this cycle's load, so a
        // coincident load stays pending for the next wrap.
        if (wrap_d && pend_flag_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pend_flag_d = 1'b0;
        end

        if (i_Load) begin
            pend_data_d  = i_DispData;
            pend_dp_d    = i_DispDP;
            pend_blank_d = i_DispBlank;
            pend_flag_d  = 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= 16'd0;
            frame_q      <= FRAME_RESET;
            wrap_q       <= 1'b0;
            pend_data_q  <= 16'd0;
            pend_dp_q    <= 4'd0;
            pend_blank_q <= 4'd0;
            pend_flag_q  <= 1'b0;
            act_data_q   <= 16'd0;
            act_dp_q     <= 4'd0;
            act_blank_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            wrap_q       <= wrap_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_flag_q  <= pend_flag_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
        end
    end

    assign o_Frame      = frame_q;
    assign o_FrameValid = (state_q == S_OFFER);
    assign o_ScanIdx    = idx_q;
    assign o_ScanWrap   = wrap_q;

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// Bench for sevenseg_scan_controller: a timing/scoreboard model checked every cycle,
// plus directed scenarios with literal frame expectations.
module tb_sevenseg_scan_controller;

    localparam int D     = 4;
    localparam int NEVER = 32'h3fffffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic        load = 1'b0;
    logic        ready = 1'b1;
    logic [12:0] frame;
    logic        valid;
    logic [1:0]  idx;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sevenseg_scan_controller #(.DWELL_CYCLES(D)) dut (
        .i_CLK        (clk),
        .i_RESET      (rst_n),
        .i_DispData   (data),
        .i_DispDP     (dp),
        .i_DispBlank  (blank),
        .i_Load       (load),
        .i_FrameReady (ready),
        .o_Frame      (frame),
        .o_FrameValid (valid),
        .o_ScanIdx    (idx),
        .o_ScanWrap   (wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Segment patterns a..g active-low for hex digits 0..F.
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [12:0] exp_frame(input logic [15:0] d, input logic [3:0] p,
                                              input logic [3:0] b, input int k);
        logic [3:0] sel;
        logic [7:0] lo;
        sel    = 4'hF;
        sel[k] = 1'b0;
        if (b[k]) lo = 8'hFF;
        else      lo = {~p[k], seg_tbl[d[4*k +: 4]]};
        return {1'b0, sel, lo};
    endfunction

    // Model: the scan is described by the cycle numbers of the next offer, the next
    // digit advance and the next wrap pulse, derived from dwell arithmetic.
    int          n = 0;
    bit          m_ok = 1'b0;
    int          offer_start = NEVER;
    int          next_fetch = NEVER;
    int          wrap_cycle = -1;
    int          m_idx = 0;
    logic [12:0] m_frame = 13'h0FFF;
    logic [15:0] a_d = 0, p_d = 0;
    logic [3:0]  a_dp = 0, p_dp = 0, a_bl = 0, p_bl = 0;
    bit          p_flag = 1'b0;

    always @(negedge clk) begin
        bit ev;
        ev = (n >= offer_start);
        if (m_ok) begin
            chk("model_frame", frame, m_frame);
            chk("model_valid", valid, ev);
            chk("model_idx", idx, m_idx[1:0]);
            chk("model_wrap", wrap, (n == wrap_cycle));
        end
        if (!rst_n) begin
            m_ok        = 1'b1;
            offer_start = n + 3;
            next_fetch  = NEVER;
            wrap_cycle  = -1;
            m_idx       = 0;
            m_frame     = 13'h0FFF;
            a_d = 0; a_dp = 0; a_bl = 0;
            p_d = 0; p_dp = 0; p_bl = 0;
            p_flag = 1'b0;
        end else if (m_ok) begin
            if (ev && ready) begin
                $display("xfer cyc=%0d digit=%0d frame=%h", n, idx, frame);
                offer_start = NEVER;
                next_fetch  = n + D + 1;
                if (m_idx == 3) wrap_cycle = n + D + 1;
            end
            if (n + 1 == next_fetch) begin
                if (m_idx == 3 && p_flag) begin
                    a_d = p_d; a_dp = p_dp; a_bl = p_bl;
                    p_flag = 1'b0;
                end
                m_idx       = (m_idx + 1) % 4;
                next_fetch  = NEVER;
                offer_start = n + 2;
            end
            if (load) begin
                p_d = data; p_dp = dp; p_bl = blank;
                p_flag = 1'b1;
            end
            if (n + 1 == offer_start) m_frame = exp_frame(a_d, a_dp, a_bl, m_idx);
        end
        n++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer(input int d, output logic [12:0] f);
        bit got;
        got = 1'b0;
        f   = 13'h0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (valid && ready && (d < 0 || int'(idx) == d)) begin
                got = 1'b1;
                f   = frame;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_xfer_d%0d: got no transfer, expected one within 300 cycles", d);
        end
    endtask

    task automatic wait_wrap();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (wrap) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_wrap: got no wrap pulse, expected one within 300 cycles");
        end
    endtask

    // Cycles from the current negedge to the next transfer (or wrap pulse).
    task automatic gap_to(input bit want_wrap, output int g);
        g = -1;
        for (int k = 1; k < 300 && g < 0; k++) begin
            @(negedge clk);
            if (want_wrap ? wrap : (valid && ready)) g = k;
        end
    endtask

    task automatic check_scan(input string name, input logic [12:0] e0, input logic [12:0] e1,
                              input logic [12:0] e2, input logic [12:0] e3);
        logic [12:0] e [4];
        logic [12:0] f;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            wait_xfer(k, f);
            chk($sformatf("%s_d%0d", name, k), f, e[k]);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        next_cycle();
        load  = 1'b1;
        data  = d;
        dp    = p;
        blank = b;
        next_cycle();
        load  = 1'b0;
    endtask

    initial begin
        logic [12:0] f;
        logic [12:0] held;
        int lat, g, cnt;
        bit bad;

        // Reset values
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_frame", frame, 13'h0FFF);
        chk("rst_valid", valid, 1'b0);
        chk("rst_idx", idx, 2'd0);
        chk("rst_wrap", wrap, 1'b0);

        // First offer two edges after release, all-zero data
        next_cycle();
        rst_n = 1'b1;
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (valid) lat = k;
        end
        chk("first_valid_latency", lat, 2);
        chk("first_frame", frame, 13'h0EC0);
        check_scan("zero", 13'h0EC0, 13'h0DC0, 13'h0BC0, 13'h07C0);
        gap_to(1'b0, g);
        chk("xfer_spacing", g, D + 2);
        wait_wrap();
        gap_to(1'b1, g);
        chk("wrap_period", g, 4 * (D + 2));

        // Load mid-scan at digit 1: digits 2,3 keep old data until the wrap
        wait_xfer(1, f);
        do_load(16'h8F1A, 4'b0001, 4'b0000);
        wait_xfer(2, f);
        chk("midscan_old_d2", f, 13'h0BC0);
        wait_xfer(3, f);
        chk("midscan_old_d3", f, 13'h07C0);
        check_scan("newdata", 13'h0E08, 13'h0DF9, 13'h0B8E, 13'h0780);

        // Back-pressure: ready low for 50 cycles during an offer
        next_cycle();
        ready = 1'b0;
        bad = 1'b0;
        lat = -1;
        for (int k = 0; k < 50 && lat < 0; k++) begin
            @(negedge clk);
            if (valid) lat = k;
        end
        chk("stall_offer_seen", (lat >= 0), 1'b1);
        held = frame;
        chk("stall_frame", held, 13'h0E08);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!valid || frame !== held) bad = 1'b1;
        end
        chk("stall_hold_stable", bad, 1'b0);
        next_cycle();
        ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < D + 2; k++) begin
            if (k > 0) @(negedge clk);
            else @(negedge clk);
            if (valid && ready) cnt++;
        end
        chk("one_xfer_after_ready", cnt, 1);

        // Blanked digit 2
        do_load(16'h8F1A, 4'b0000, 4'b0100);
        @(negedge clk);
        wait_wrap();
        check_scan("blank", 13'h0E88, 13'h0DF9, 13'h0BFF, 13'h0780);

        // Last pre-wrap load wins; a load on the wrap edge waits one more scan
        wait_xfer(0, f);
        do_load(16'h1234, 4'b0000, 4'b0000);
        wait_xfer(1, f);
        do_load(16'h5678, 4'b0000, 4'b0000);
        wait_xfer(3, f);
        repeat (D) next_cycle();
        load = 1'b1;
        data = 16'h9ABC;
        next_cycle();
        load = 1'b0;
        check_scan("last_wins", 13'h0E80, 13'h0DF8, 13'h0B82, 13'h0792);
        check_scan("coincident", 13'h0EC6, 13'h0D83, 13'h0B88, 13'h0790);

        // Reset during the dwell of digit 2
        wait_xfer(2, f);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("midreset_frame", frame, 13'h0FFF);
        chk("midreset_valid", valid, 1'b0);
        chk("midreset_idx", idx, 2'd0);
        next_cycle();
        rst_n = 1'b1;
        check_scan("after_reset", 13'h0EC0, 13'h0DC0, 13'h0BC0, 13'h07C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
        $fatal(1, "timeout");
    end

endmodule
